cvxif_reg_loader: RTL and testbench

- Upstream feeder for the CVXIF non-addressed register bank.
- Accepts packed custom-instruction operands through a valid/ready request port. The operand is rs2 concatenated with rs1, 64 bits total.
- Unpacks REG_WIDTH-bit values and serialises them as one write strobe per cycle onto the bank's write-enable/write-data inputs.
- Forwards dump commands. Tracks bank fill level so values beyond capacity are dropped and flagged, never written.
- Returns a per-command response.

---
 rtl/cvxif_reg_loader_if.sv | 37 +++
 rtl/cvxif_reg_loader.sv | 147 ++++++++++++++
 tb/tb_cvxif_reg_loader.sv | 306 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cvxif_reg_loader_if.sv
// Request/response and bank-write bundle between a command source and cvxif_reg_loader.
// Signal names keep the loader's _i/_o port suffixes as seen from the loader side.
interface cvxif_reg_loader_if #(
    parameter int REG_WIDTH = 9,
    parameter int SLOTS     = 7,
    parameter int CNT_W     = 8
);
    localparam int CW = $clog2(SLOTS + 1);

    logic                 req_valid_i;
    logic                 req_ready_o;
    logic [1:0]           req_op_i;
    logic [63:0]          req_data_i;
    logic [CW-1:0]        req_count_i;
    logic                 we_o;
    logic [REG_WIDTH-1:0] wb_data_o;
    logic                 dump_o;
    logic [CNT_W-1:0]     fill_count_o;
    logic                 full_o;
    logic                 overflow_o;
    logic                 resp_valid_o;
    logic                 resp_ready_i;
    logic [CW-1:0]        resp_written_o;
    logic                 resp_error_o;

    modport master (
        output req_valid_i, req_op_i, req_data_i, req_count_i, resp_ready_i,
        input  req_ready_o, we_o, wb_data_o, dump_o, fill_count_o, full_o,
               overflow_o, resp_valid_o, resp_written_o, resp_error_o
    );

    modport slave (
        input  req_valid_i, req_op_i, req_data_i, req_count_i, resp_ready_i,
        output req_ready_o, we_o, wb_data_o, dump_o, fill_count_o, full_o,
               overflow_o, resp_valid_o, resp_written_o, resp_error_o
    );
endinterface

// File: rtl/cvxif_reg_loader.sv
// Unpacks LOAD operands into one bank write per cycle, forwards DUMP as a clear
// pulse, tracks bank fill level and returns one response per command.
module cvxif_reg_loader #(
    parameter int NB_OF_REGS = 150,
    parameter int REG_WIDTH  = 9,
    parameter int SLOTS      = 7,
    parameter int CNT_W      = $clog2(NB_OF_REGS + 1)
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    cvxif_reg_loader_if.slave  bus
);
    localparam int CW = $clog2(SLOTS + 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EMIT = 2'd1;
    localparam logic [1:0] DUMP = 2'd2;
    localparam logic [1:0] RESP = 2'd3;

    localparam logic [1:0] OP_LOAD = 2'b01;
    localparam logic [1:0] OP_DUMP = 2'b10;

    logic [1:0]           state_q,   state_d;
    logic [63:0]          data_q,    data_d;
    logic [CW-1:0]        rem_q,     rem_d;
    logic [CW-1:0]        written_q, written_d;
    logic                 error_q,   error_d;
    logic [CNT_W-1:0]     fill_q,    fill_d;
    logic                 ovf_q,     ovf_d;
    logic                 we_q,      we_d;
    logic [REG_WIDTH-1:0] wb_q,      wb_d;
    logic                 dump_q,    dump_d;

    logic                 emit_go;
    logic [REG_WIDTH-1:0] emit_val;

    // The operand is kept right-shifted so the next slot is always in the low bits;
    // slot 0 is emitted straight from the request so its strobe lands the cycle after accept.
    always_comb begin
        state_d   = state_q;
        data_d    = data_q;
        rem_d     = rem_q;
        written_d = written_q;
        error_d   = error_q;
        fill_d    = fill_q;
        ovf_d     = ovf_q;
        we_d      = 1'b0;
        wb_d      = '0;
        dump_d    = 1'b0;
        emit_go   = 1'b0;
        emit_val  = '0;

        case (state_q)
            IDLE: begin
                if (bus.req_valid_i) begin
                    written_d = '0;
                    error_d   = 1'b0;
                    rem_d     = '0;
                    data_d    = bus.req_data_i;
                    if (bus.req_op_i == OP_LOAD) begin
                        if (bus.req_count_i != '0) begin
                            emit_go  = 1'b1;
                            emit_val = bus.req_data_i[REG_WIDTH-1:0];
                            data_d   = bus.req_data_i >> REG_WIDTH;
                            rem_d    = bus.req_count_i - 1'b1;
                            state_d  = EMIT;
                        end else begin
                            state_d  = RESP;
                        end
                    end else if (bus.req_op_i == OP_DUMP) begin
                        dump_d  = 1'b1;
                        fill_d  = '0;
                        ovf_d   = 1'b0;
                        state_d = DUMP;
                    end else begin
                        error_d = 1'b1;
                        state_d = RESP;
                    end
                end
            end
            EMIT: begin
                if (rem_q != '0) begin
                    emit_go  = 1'b1;
                    emit_val = data_q[REG_WIDTH-1:0];
                    data_d   = data_q >> REG_WIDTH;
                    rem_d    = rem_q - 1'b1;
                end else begin
                    state_d  = RESP;
                end
            end
            DUMP: state_d = RESP;
            default: begin
                if (bus.resp_ready_i) state_d = IDLE;
            end
        endcase

        // A full bank swallows the value: no strobe, sticky overflow, command error.
        if (emit_go) begin
            if (fill_q != CNT_W'(NB_OF_REGS)) begin
                we_d      = 1'b1;
                wb_d      = emit_val;
                fill_d    = fill_q + 1'b1;
                written_d = written_d + 1'b1;
            end else begin
                ovf_d   = 1'b1;
                error_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            data_q    <= '0;
            rem_q     <= '0;
            written_q <= '0;
            error_q   <= 1'b0;
            fill_q    <= '0;
            ovf_q     <= 1'b0;
            we_q      <= 1'b0;
            wb_q      <= '0;
            dump_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            data_q    <= data_d;
            rem_q     <= rem_d;
            written_q <= written_d;
            error_q   <= error_d;
            fill_q    <= fill_d;
            ovf_q     <= ovf_d;
            we_q      <= we_d;
            wb_q      <= wb_d;
            dump_q    <= dump_d;
        end
    end

    assign bus.req_ready_o    = (state_q == IDLE);
    assign bus.resp_valid_o   = (state_q == RESP);
    assign bus.resp_written_o = (state_q == RESP) ? written_q : '0;
    assign bus.resp_error_o   = (state_q == RESP) ? error_q : 1'b0;
    assign bus.we_o           = we_q;
    assign bus.wb_data_o      = wb_q;
    assign bus.dump_o         = dump_q;
    assign bus.fill_count_o   = fill_q;
    assign bus.full_o         = (fill_q == CNT_W'(NB_OF_REGS));
    assign bus.overflow_o     = ovf_q;
endmodule

// File: tb/tb_cvxif_reg_loader.sv
// Scoreboard bench for cvxif_reg_loader: a command-level model pushes expected
// strobes, dumps and responses; monitors pop and compare as the DUT presents them.
module tb_cvxif_reg_loader;
   localparam int NB    = 150;
   localparam int RW    = 9;
   localparam int SLOTS = 7;
   localparam int CNT_W = 8;

   typedef struct {
      int written;
      bit error;
      int fill;
      bit ovf;
      int cyc;
   } resp_t;

   typedef struct {
      int data;
      int cyc;
   } wr_t;

   logic clk = 1'b0;
   logic rstN = 1'b0;

   resp_t respQ[$];
   wr_t   wrQ[$];
   int    dumpQ[$];

   int tests = 0;
   int fails = 0;
   int cyc = 0;
   int modelFill = 0;
   bit modelOvf = 1'b0;
   bit stall = 1'b0;
   bit monEn = 1'b0;

   cvxif_reg_loader_if #(.REG_WIDTH(RW), .SLOTS(SLOTS), .CNT_W(CNT_W)) bus ();

   cvxif_reg_loader #(
      .NB_OF_REGS(NB),
      .REG_WIDTH (RW),
      .SLOTS     (SLOTS)
   ) dut (
      .clk_i (clk),
      .rst_ni(rstN),
      .bus   (bus)
   );

   // Free-running clock and a cycle stamp used for latency expectations
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Response consumer: randomly back-pressures unless the stall phase holds it low
   always @(posedge clk) begin
      #1;
      bus.resp_ready_i = stall ? 1'b0 : ($urandom_range(0, 3) != 0);
   end

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic checkReset(input string tag);
      checkOutput({tag, "_req_ready"}, 64'(bus.req_ready_o), 64'd1);
      checkOutput({tag, "_we"}, 64'(bus.we_o), 64'd0);
      checkOutput({tag, "_dump"}, 64'(bus.dump_o), 64'd0);
      checkOutput({tag, "_resp_valid"}, 64'(bus.resp_valid_o), 64'd0);
      checkOutput({tag, "_resp_error"}, 64'(bus.resp_error_o), 64'd0);
      checkOutput({tag, "_wb_data"}, 64'(bus.wb_data_o), 64'd0);
      checkOutput({tag, "_fill"}, 64'(bus.fill_count_o), 64'd0);
      checkOutput({tag, "_resp_written"}, 64'(bus.resp_written_o), 64'd0);
      checkOutput({tag, "_full"}, 64'(bus.full_o), 64'd0);
      checkOutput({tag, "_overflow"}, 64'(bus.overflow_o), 64'd0);
   endtask

   // Command-level reference: each offered value either lands (one strobe, k cycles
   // after accept) or is dropped once the bank holds NB values
   task automatic modelCommand(input logic [1:0] op, input int count, input logic [63:0] data, input int acc);
      resp_t r;
      wr_t w;
      logic [63:0] v;
      r.written = 0;
      r.error = 1'b0;
      if (op == 2'b01) begin
         for (int k = 0; k < count; k++) begin
            v = (data >> (k * RW)) & 64'h1FF;
            if (modelFill < NB) begin
               w.data = int'(v);
               w.cyc = acc + k;
               wrQ.push_back(w);
               modelFill++;
               r.written++;
            end else begin
               r.error = 1'b1;
               modelOvf = 1'b1;
            end
         end
         r.cyc = (count == 0) ? acc : acc + count;
      end else if (op == 2'b10) begin
         modelFill = 0;
         modelOvf = 1'b0;
         dumpQ.push_back(acc);
         r.cyc = acc + 1;
      end else begin
         r.error = 1'b1;
         r.cyc = acc;
      end
      r.fill = modelFill;
      r.ovf = modelOvf;
      respQ.push_back(r);
   endtask

   task automatic applyStimulus(input logic [1:0] op, input int count, input logic [63:0] data);
      int waitCnt;
      int acc;
      @(posedge clk);
      #1;
      bus.req_valid_i = 1'b1;
      bus.req_op_i = op;
      bus.req_count_i = 3'(count);
      bus.req_data_i = data;
      waitCnt = 0;
      forever begin
         @(negedge clk);
         if (bus.req_ready_o) break;
         waitCnt++;
         if (waitCnt > 300) begin
            checkOutput("accept_timeout", 64'd0, 64'd1);
            bus.req_valid_i = 1'b0;
            return;
         end
      end
      @(posedge clk);
      #1;
      acc = cyc;
      bus.req_valid_i = 1'b0;
      modelCommand(op, count, data, acc);
   endtask

   task automatic waitDrain();
      int waitCnt = 0;
      while (respQ.size() != 0 || wrQ.size() != 0 || dumpQ.size() != 0) begin
         @(posedge clk);
         waitCnt++;
         if (waitCnt > 500) begin
            checkOutput("drain_timeout", 64'd0, 64'd1);
            break;
         end
      end
      repeat (2) @(posedge clk);
   endtask

   // Monitor: every strobe, dump pulse and accepted response must match the next expectation
   bit seen = 1'b0;
   int firstCyc = 0;
   always @(negedge clk) begin
      wr_t w;
      resp_t r;
      int d;
      if (!rstN) begin
         seen = 1'b0;
      end else if (monEn) begin
         if (bus.we_o) begin
            if (wrQ.size() == 0) begin
               checkOutput("unexpected_we", 64'd1, 64'd0);
            end else begin
               w = wrQ.pop_front();
               checkOutput("wb_data", 64'(bus.wb_data_o), 64'(w.data));
               checkOutput("we_cycle", 64'(cyc), 64'(w.cyc));
            end
         end
         if (bus.dump_o) begin
            if (dumpQ.size() == 0) begin
               checkOutput("unexpected_dump", 64'd1, 64'd0);
            end else begin
               d = dumpQ.pop_front();
               checkOutput("dump_cycle", 64'(cyc), 64'(d));
               checkOutput("dump_fill", 64'(bus.fill_count_o), 64'd0);
               checkOutput("dump_overflow", 64'(bus.overflow_o), 64'd0);
            end
         end
         if (bus.resp_valid_o && !seen) begin
            seen = 1'b1;
            firstCyc = cyc;
         end
         if (bus.resp_valid_o && bus.resp_ready_i) begin
            seen = 1'b0;
            if (respQ.size() == 0) begin
               checkOutput("unexpected_resp", 64'd1, 64'd0);
            end else begin
               r = respQ.pop_front();
               checkOutput("resp_written", 64'(bus.resp_written_o), 64'(r.written));
               checkOutput("resp_error", 64'(bus.resp_error_o), 64'(r.error));
               checkOutput("resp_cycle", 64'(firstCyc), 64'(r.cyc));
               checkOutput("fill_count", 64'(bus.fill_count_o), 64'(r.fill));
               checkOutput("full", 64'(bus.full_o), 64'(r.fill == NB));
               checkOutput("overflow", 64'(bus.overflow_o), 64'(r.ovf));
            end
         end
      end
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation did not finish");
      $fatal(1, "[TB] watchdog expired");
   end

   // Directed scenarios first, then a randomized command stream
   initial begin
      logic [63:0] d;
      int waitCnt;
      int r;
      logic [1:0] op;

      bus.req_valid_i = 1'b0;
      bus.req_op_i = 2'b00;
      bus.req_data_i = '0;
      bus.req_count_i = '0;
      bus.resp_ready_i = 1'b0;

      repeat (3) @(posedge clk);
      #1;
      checkReset("reset");
      @(negedge clk);
      rstN = 1'b1;
      monEn = 1'b1;

      d = {$urandom(), $urandom()};
      d[26:0] = {9'h0AA, 9'h1FF, 9'h001};
      applyStimulus(2'b01, 3, d);
      waitDrain();

      for (int i = 0; i < 22; i++) applyStimulus(2'b01, 7, {$urandom(), $urandom()});
      waitDrain();

      applyStimulus(2'b10, 0, {$urandom(), $urandom()});
      waitDrain();

      applyStimulus(2'b11, 5, {$urandom(), $urandom()});
      applyStimulus(2'b01, 0, {$urandom(), $urandom()});
      applyStimulus(2'b00, 3, {$urandom(), $urandom()});
      waitDrain();

      stall = 1'b1;
      @(posedge clk);
      #2;
      applyStimulus(2'b01, 2, {$urandom(), $urandom()});
      waitCnt = 0;
      do begin
         @(negedge clk);
         waitCnt++;
      end while (!bus.resp_valid_o && waitCnt < 50);
      checkOutput("stall_resp_seen", 64'(bus.resp_valid_o), 64'd1);
      bus.req_valid_i = 1'b1;
      bus.req_op_i = 2'b01;
      bus.req_count_i = 3'd1;
      bus.req_data_i = {$urandom(), $urandom()};
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         checkOutput("stall_resp_valid", 64'(bus.resp_valid_o), 64'd1);
         checkOutput("stall_req_ready", 64'(bus.req_ready_o), 64'd0);
         checkOutput("stall_written", 64'(bus.resp_written_o), 64'(respQ[0].written));
         checkOutput("stall_error", 64'(bus.resp_error_o), 64'(respQ[0].error));
      end
      bus.req_valid_i = 1'b0;
      stall = 1'b0;
      waitDrain();

      applyStimulus(2'b01, 5, {$urandom(), $urandom()});
      @(negedge clk);
      @(negedge clk);
      #1;
      rstN = 1'b0;
      #1;
      checkReset("midreset");
      wrQ.delete();
      respQ.delete();
      dumpQ.delete();
      modelFill = 0;
      modelOvf = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rstN = 1'b1;
      repeat (6) @(negedge clk);
      checkOutput("post_reset_req_ready", 64'(bus.req_ready_o), 64'd1);

      for (int i = 0; i < 60; i++) begin
         r = $urandom_range(0, 9);
         if (r < 7) op = 2'b01;
         else if (r < 9) op = 2'b10;
         else op = ($urandom_range(0, 1) != 0) ? 2'b11 : 2'b00;
         applyStimulus(op, $urandom_range(0, SLOTS), {$urandom(), $urandom()});
      end
      waitDrain();

      checkOutput("queues_empty", 64'(respQ.size() + wrQ.size() + dumpQ.size()), 64'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
